cache_tag_ctrl: RTL
===================

CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 SHALL have no parameters; geometry fixed: 4 ways, fully associative, 16-byte lines, tag = addr[19:4] (16 bits).
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rsn_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port read_valid_i  in  1  read lookup request this cycle.
REQ-005 SHALL have port read_addr_i  in  20  read byte address.
REQ-006 SHALL have port write_enable_i  in  1  store request this cycle.
REQ-007 SHALL have port write_addr_i  in  20  store byte address.
REQ-008 SHALL have port mem_data_ready_i  in  1  memory line-fill return strobe.
REQ-009 SHALL have ports read_hit_way_o, write_hit_way_o, lru_way_o  out  2 each: matching read way, matching write way, fill victim way.
REQ-010 SHALL have ports read_hit_o, write_hit_o, read_miss_o  out  1 each: lookup results.
REQ-011 SHALL have ports mem_req_o  out  1  fill request; mem_addr_o  out  20  line-aligned fill address.
REQ-012 SHALL have port stall_o  out  1  pipeline must hold current read.

Function
REQ-013 SHALL hold per way: valid bit, 16-bit tag, 2-bit LRU age (0 = MRU, 3 = LRU); ages always a permutation of 0..3.
REQ-014 SHALL implement states IDLE and FILL.
REQ-015 In IDLE, read_hit_o SHALL be combinational: read_valid_i and some valid way tag equals read_addr_i[19:4]; read_hit_way_o = that way index (0 when no hit).
REQ-016 In IDLE, read_miss_o SHALL equal read_valid_i and not read_hit_o; in FILL, read_hit_o and read_miss_o SHALL be 0.
REQ-017 write_hit_o SHALL be write_enable_i and tag match on write_addr_i[19:4], IDLE only; write_hit_way_o = matching way (0 otherwise); write miss SHALL not allocate or change state (write-through, no-allocate).
REQ-018 In IDLE, lru_way_o SHALL be the lowest-index invalid way, else the way with age 3; in FILL, lru_way_o SHALL be the victim registered at the miss, stable for the entire FILL.
REQ-019 On read_miss_o: next cycle state=FILL, victim and mem_addr_o = {read_addr_i[19:4], 4'b0} registered.
REQ-020 mem_req_o SHALL be 1 in every FILL cycle including the mem_data_ready_i cycle, 0 in IDLE; mem_addr_o holds its last value in IDLE.
REQ-021 In FILL with mem_data_ready_i=1: victim tag <= fill tag, valid <= 1, victim becomes MRU, state <= IDLE; replayed read hits on following cycle.
REQ-022 mem_data_ready_i in IDLE SHALL be ignored.
REQ-023 stall_o SHALL be 1 when state=FILL or read_miss_o=1, else 0.
REQ-024 LRU update on access of way w: ways with age < age[w] increment, age[w] <= 0; update source priority: fill completion, else read hit way, else write hit way (one update per cycle).
REQ-025 Miss latency: read_miss_o at cycle N, mem_req_o from N+1, earliest fill at N+1, read_hit_o at N+2.

Reset
REQ-026 On rsn_i=0 at a rising edge: state IDLE, all valid 0, ages way0..3 = 0,1,2,3, mem_addr_o 0, registered victim 0; takes priority over all other events.
REQ-027 Reset during FILL SHALL abandon the fill: mem_req_o 0 next cycle, no tag installed.
REQ-028 After reset, with no requests, all outputs SHALL be 0.

Verification
REQ-029 Cold read 0x12345 -> read_miss_o=1, lru_way_o=0, stall_o=1; next cycle mem_req_o=1, mem_addr_o=0x12340; ready after 3 cycles -> next cycle read 0x12348 gives read_hit_o=1, way 0.
REQ-030 Fill ways 0..3 with lines 0x00000,0x00010,0x00020,0x00030, then read 0x00000 -> hit way 0; next miss 0x00040 -> lru_way_o=1.
REQ-031 Write 0x00014 with line 0x00010 resident -> write_hit_o=1, write_hit_way_o=1; write 0x0FF00 absent -> write_hit_o=0, no mem_req_o.
REQ-032 Write hit during FILL -> write_hit_o=0; read_valid_i during FILL -> read_miss_o=0, stall_o=1.
REQ-033 rsn_i=0 two cycles into FILL -> mem_req_o=0 next cycle; re-read same address -> read_miss_o=1, lru_way_o=0.
REQ-034 mem_data_ready_i pulse in IDLE -> no tag, valid or LRU change.

Source files
------------

// File: rtl/cache_tag_ctrl.sv
// Tag and replacement controller for a 4-way fully associative cache with 16-byte lines.
// Read misses stall the pipeline and request a line fill; stores are write-through, no-allocate.
module cache_tag_ctrl (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        read_valid_i,
    input  logic [19:0] read_addr_i,
    input  logic        write_enable_i,
    input  logic [19:0] write_addr_i,
    input  logic        mem_data_ready_i,
    output logic [1:0]  read_hit_way_o,
    output logic [1:0]  write_hit_way_o,
    output logic [1:0]  lru_way_o,
    output logic        read_hit_o,
    output logic        write_hit_o,
    output logic        read_miss_o,
    output logic        mem_req_o,
    output logic [19:0] mem_addr_o,
    output logic        stall_o
);

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_valid [4];
    logic [15:0] r_tag   [4];
    logic [1:0]  r_age   [4];
    logic [1:0]  r_victim;
    logic [15:0] r_fill_tag;

    logic [15:0] w_rd_tag;
    logic [15:0] w_wr_tag;
    logic [3:0]  w_rd_match;
    logic [3:0]  w_wr_match;
    logic [3:0]  w_invalid;
    logic [3:0]  w_oldest;
    logic [1:0]  w_rd_way;
    logic [1:0]  w_wr_way;
    logic [1:0]  w_idle_victim;
    logic        w_fill_done;
    logic        w_touch_en;
    logic [1:0]  w_touch_way;
    logic        w_unused;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign w_rd_tag = read_addr_i[19:4];
    assign w_wr_tag = write_addr_i[19:4];
    assign w_unused = ^{read_addr_i[3:0], write_addr_i[3:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_way
            assign w_rd_match[gi] = r_valid[gi] && (r_tag[gi] == w_rd_tag);
            assign w_wr_match[gi] = r_valid[gi] && (r_tag[gi] == w_wr_tag);
            assign w_invalid[gi]  = !r_valid[gi];
            assign w_oldest[gi]   = (r_age[gi] == 2'd3);
        end
    endgenerate

    assign w_rd_way      = first_set(w_rd_match);
    assign w_wr_way      = first_set(w_wr_match);
    // Empty ways are consumed before any valid line is evicted.
    assign w_idle_victim = (|w_invalid) ? first_set(w_invalid) : first_set(w_oldest);
    assign w_fill_done   = (r_state == S_FILL) && mem_data_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (read_valid_i && !(|w_rd_match)) w_state_next = S_FILL;
            S_FILL:  if (mem_data_ready_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        read_hit_o      = 1'b0;
        read_hit_way_o  = 2'd0;
        read_miss_o     = 1'b0;
        write_hit_o     = 1'b0;
        write_hit_way_o = 2'd0;
        lru_way_o       = r_victim;
        mem_req_o       = 1'b0;
        stall_o         = 1'b1;
        mem_addr_o      = {r_fill_tag, 4'h0};
        if (r_state == S_IDLE) begin
            read_hit_o      = read_valid_i && (|w_rd_match);
            read_hit_way_o  = read_hit_o ? w_rd_way : 2'd0;
            read_miss_o     = read_valid_i && !(|w_rd_match);
            write_hit_o     = write_enable_i && (|w_wr_match);
            write_hit_way_o = write_hit_o ? w_wr_way : 2'd0;
            lru_way_o       = w_idle_victim;
            stall_o         = read_miss_o;
        end else begin
            mem_req_o = 1'b1;
        end
    end

    // One recency update per cycle: fill completion wins over a read hit, which wins over a write hit.
    always_comb begin
        w_touch_en  = 1'b0;
        w_touch_way = 2'd0;
        if (w_fill_done) begin
            w_touch_en  = 1'b1;
            w_touch_way = r_victim;
        end else if (read_hit_o) begin
            w_touch_en  = 1'b1;
            w_touch_way = w_rd_way;
        end else if (write_hit_o) begin
            w_touch_en  = 1'b1;
            w_touch_way = w_wr_way;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_victim   <= 2'd0;
            r_fill_tag <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= 16'd0;
                r_age[i]   <= 2'(i);
            end
        end else begin
            if (read_miss_o) begin
                r_victim   <= w_idle_victim;
                r_fill_tag <= w_rd_tag;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_fill_done && (r_victim == 2'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_tag[i]   <= r_fill_tag;
                end
                if (w_touch_en) begin
                    if (w_touch_way == 2'(i)) begin
                        r_age[i] <= 2'd0;
                    end else if (r_age[i] < r_age[w_touch_way]) begin
                        r_age[i] <= r_age[i] + 2'd1;
                    end
                end
            end
        end
    end

endmodule
